// File: rtl/hevc_fir_pkg.sv
// Shared constants, coefficient tables and types for the HEVC 8-tap luma accumulator.
package hevc_fir_pkg;

  localparam int IN_W   = 16;
  localparam int OUT_W  = 27;
  localparam int NTAP   = 8;
  localparam int COEF_W = 8;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [OUT_W-1:0]  out_sum_t;

  // Row r holds the taps for fractional phase r+1; every row sums to 64.
  localparam int COEF_TAB [3][NTAP] = '{
    '{-1, 4, -10, 58, 17,  -5, 1,  0},
    '{-1, 4, -11, 40, 40, -11, 4, -1},
    '{ 0, 1,  -5, 17, 58, -10, 4, -1}
  };

  function automatic coef_t fir_coef(input int frac, input logic [2:0] k);
    int row;
    row = (frac >= 1 && frac <= 3) ? frac - 1 : 1;
    return coef_t'(COEF_TAB[row][k]);
  endfunction

endpackage

// File: rtl/fir8_lane.sv
// Per-flux tap counter and partial-sum accumulator.
module fir8_lane #(
  parameter int W = 27
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel,
  input  logic signed [W-1:0] prod,
  output logic [2:0]          tap,
  output logic                tap_is_last,
  output logic signed [W-1:0] sum_nxt
);

  logic [2:0]          tap_q, tap_d;
  logic signed [W-1:0] acc_q, acc_d;

  always_comb begin
    sum_nxt = acc_q + prod;
    tap_d   = tap_q;
    acc_d   = acc_q;
    if (sel) begin
      if (tap_q == 3'd7) begin
        tap_d = '0;
        acc_d = '0;
      end else begin
        tap_d = tap_q + 3'd1;
        acc_d = sum_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_q <= '0;
      acc_q <= '0;
    end else begin
      tap_q <= tap_d;
      acc_q <= acc_d;
    end
  end

  assign tap         = tap_q;
  assign tap_is_last = (tap_q == 3'd7);

endmodule

// File: rtl/hevc_fir8_acc.sv
// Second-pass 8-tap luma interpolation accumulator, FLUX fluxes through one shared MAC.
// HEVC_FIR_OUTREG_EN adds a one-entry output register between the MAC and the write port.
module hevc_fir8_acc
  import hevc_fir_pkg::*;
#(
  parameter int FLUX               = 2,
  parameter int FRAC               = 2,
  parameter int IN_PEL_DATA_WIDTH  = 16,
  parameter int OUT_PEL_DATA_WIDTH = 27,
  parameter int TAG_WIDTH          = $clog2(FLUX)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [FLUX-1:0]                           read_port_in_pel_empty,
  output logic [FLUX-1:0]                           read_port_in_pel_read,
  input  logic [TAG_WIDTH+IN_PEL_DATA_WIDTH:0]      read_port_in_pel_dout,
  input  logic [FLUX-1:0]                           write_port_out_pel_full,
  output logic                                      write_port_out_pel_write,
  output logic [TAG_WIDTH+OUT_PEL_DATA_WIDTH:0]     write_port_out_pel_din
);

  localparam int TW1 = TAG_WIDTH + 1;
  localparam int OW  = OUT_PEL_DATA_WIDTH;
  localparam int IW  = IN_PEL_DATA_WIDTH;

  typedef struct packed {
    logic [TW1-1:0]       tag;
    logic signed [OW-1:0] sum;
  } out_word_t;

  logic [FLUX-1:0]          elig, sel_oh, last_ok, lane_last;
  logic [FLUX-1:0][2:0]     lane_tap;
  logic [FLUX-1:0][OW-1:0]  lane_sum;
  logic                     found, sel_last;
  logic [TW1-1:0]           sel_tag;
  logic [2:0]               sel_tap;
  logic signed [IW-1:0]     smp;
  coef_t                    coef;
  logic signed [OW-1:0]     prod;
  out_word_t                sel_word;
  logic                     unused_dout_tag;

  assign unused_dout_tag = ^read_port_in_pel_dout[TAG_WIDTH+IW:IW];

  // Fixed priority: lowest-index eligible flux owns the MAC this cycle.
  always_comb begin
    elig     = '0;
    sel_oh   = '0;
    found    = 1'b0;
    sel_tag  = '1;
    sel_tap  = '0;
    sel_last = 1'b0;
    for (int f = 0; f < FLUX; f++) begin
      elig[f] = !read_port_in_pel_empty[f] && (!lane_last[f] || last_ok[f]);
      if (elig[f] && !found) begin
        found     = 1'b1;
        sel_oh[f] = 1'b1;
        sel_tag   = TW1'(f);
        sel_tap   = lane_tap[f];
        sel_last  = lane_last[f];
      end
    end
  end

  assign read_port_in_pel_read = sel_oh;

  always_comb begin
    smp  = read_port_in_pel_dout[IW-1:0];
    coef = fir_coef(FRAC, sel_tap);
    prod = OW'(smp) * OW'(coef);
  end

  for (genvar f = 0; f < FLUX; f++) begin : g_lane
    fir8_lane #(.W(OW)) u_lane (
      .clk         (clk),
      .rst         (rst),
      .sel         (sel_oh[f]),
      .prod        (prod),
      .tap         (lane_tap[f]),
      .tap_is_last (lane_last[f]),
      .sum_nxt     (lane_sum[f])
    );
  end

  always_comb begin
    sel_word.tag = sel_tag;
    sel_word.sum = '0;
    for (int f = 0; f < FLUX; f++)
      if (sel_oh[f]) sel_word.sum = lane_sum[f];
  end

`ifdef HEVC_FIR_OUTREG_EN
  logic      ovld_q, ovld_d, ofull, drain, load;
  out_word_t oword_q, oword_d;

  always_comb begin
    ofull = 1'b0;
    for (int f = 0; f < FLUX; f++)
      if (oword_q.tag == TW1'(f)) ofull = write_port_out_pel_full[f];
    drain = ovld_q && !ofull;
    for (int f = 0; f < FLUX; f++)
      last_ok[f] = !ovld_q || (drain && !write_port_out_pel_full[f]);
  end

  always_comb begin
    load    = found && sel_last;
    ovld_d  = load || (ovld_q && !drain);
    oword_d = load ? sel_word : oword_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovld_q  <= 1'b0;
      oword_q <= '0;
    end else begin
      ovld_q  <= ovld_d;
      oword_q <= oword_d;
    end
  end

  always_comb begin
    write_port_out_pel_write = drain;
    write_port_out_pel_din   = drain ? oword_q : '0;
  end
`else
  assign last_ok = ~write_port_out_pel_full;

  always_comb begin
    write_port_out_pel_write = found && sel_last;
    write_port_out_pel_din   = write_port_out_pel_write ? sel_word : '0;
  end
`endif

endmodule
